data_mem: RTL and testbench
===========================

# data_mem

Word-organised data memory for the MEM stage of the pipelined CPU. It accepts the ALU-computed address and store data from EX/MEM, performs sw/sh/sb writes with byte-lane merging, and returns the full aligned word combinationally. The downstream load-extension stage selects and extends the byte or halfword for lb/lbu/lh/lhu. After reset, a hardware sweep zeroes the whole array while `busy` stalls the pipeline.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words (4 KiB). Must be a power of two, at least 2.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `pc`  in  32: PC of the instruction in MEM. Used only for the write log.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data. sh uses bits [15:0]; sb uses bits [7:0].
- `store_op`  in  2: 00 none, 01 sw, 10 sh, 11 sb.
- `rdata`  out  32: aligned word at `addr`. Combinational read.
- `busy`  out  1: clear sweep in progress. The pipeline must stall.
- `align_err`  out  1: the store is misaligned (combinational).
- `range_err`  out  1: the word index is at or above `DEPTH_WORDS` (combinational).

## Operation
- Word index is `addr[AW+1:2]`, with AW = log2(DEPTH_WORDS). Any nonzero bit in `addr[31:AW+2]` asserts `range_err`.
- Misalignment rules:
  - sw: `addr[1:0]` != 0 is misaligned.
  - sh: `addr[0]` = 1 is misaligned.
  - sb: never misaligned.
  - `align_err` is asserted only when `store_op` != 00.
- Write enable = (`store_op` != 00) && !`busy` && !`align_err` && !`range_err`. A suppressed store leaves memory unchanged.
- Byte-lane merge for stores:
  - sw: replaces the whole word.
  - sh: writes lanes [15:0] when `addr[1]`=0, lanes [31:16] when `addr[1]`=1.
  - sb: writes byte lane `addr[1:0]` with `wdata[7:0]`.
  - Unselected lanes keep their old value.
- Read behaviour:
  - `rdata` = array[index] when !`busy` && !`range_err`; otherwise 0.
  - There is no byte selection here; load extension happens downstream.
- Clear FSM has two states, CLEAR and IDLE.
  - While `reset` is low: the FSM is held in CLEAR and the counter is 0.
  - In CLEAR: each cycle writes 0 to array[counter] and increments the counter. When counter = DEPTH_WORDS-1 is written, the FSM moves to IDLE.
  - IDLE is terminal until the next reset.

## Timing
- Reset values: `busy`=1; FSM=CLEAR; counter=0. `rdata`=0 while busy. `align_err` and `range_err` follow their inputs at all times.
- The sweep takes exactly DEPTH_WORDS cycles after `reset` deasserts. `busy` falls on the edge that writes the last word.
- A store takes effect at the rising edge. Same-cycle read of the same address returns the old word; the new word is visible in the next cycle.
- Reset asserted mid-sweep: counter returns to 0 immediately and the sweep restarts on deassertion. Array contents are undefined until the sweep completes.
- Stores presented while `busy`=1 are dropped. The pipeline is required to hold them; this block does not queue them.
- Read latency is 0 cycles; write latency is 1 edge.

## Configuration
- `DM_WRITE_LOG_EN` defined: on every enabled store edge, emit `$display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word)`. The clear sweep and suppressed stores are not logged.
- `DM_WRITE_LOG_EN` undefined: no log is emitted. The `pc` port remains but is unused.

## Structure
- Package `dm_pkg` holds:
  - the `store_op` encodings: ST_NONE, ST_W, ST_H, ST_B;
  - the FSM state constants;
  - the default DEPTH_WORDS.
- Sub-module `dm_byte_merge` is combinational. Inputs: old word, `wdata`, `store_op`, `addr[1:0]`. Output: merged word.
- The top level owns the array, the clear FSM/counter, the enable logic and the error flags.

## Test plan
- Reset, then release: `busy`=1 for exactly DEPTH_WORDS cycles; afterwards a read at 0x0 and at 0xFFC returns 0x00000000.
- sw 0x12345678 @0x10, then sh 0xBEEF @0x12, then sb 0xAA @0x11: read @0x10 returns 0xBEEFAA78.
- sw @0x06 and sh @0x03: `align_err`=1 and the word is unchanged; sb @0x03 writes lane 3 with `align_err`=0.
- Store @0x1000 with DEPTH_WORDS=1024: `range_err`=1, `rdata`=0, no write; word 0 is not aliased.
- sw 0xFFFFFFFF @0x20 during the sweep: dropped, so a read after `busy` falls returns 0. Reset pulsed at sweep cycle 500: `busy` stays 1 for a full DEPTH_WORDS cycles after release.
- With `DM_WRITE_LOG_EN`, sw 0x5 @0x8 from pc 0x3000: exactly one line `@00003000: *00000008 <= 00000005`.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the MEM-stage data memory.
// Holds the store_op encodings, the clear-FSM state constants, the default
// depth and the store alignment rule shared by the top level.
`timescale 1ns/1ps
package dm_pkg;

  // Default array size in 32-bit words (4 KiB).
  localparam int DM_DEPTH_WORDS_DEFAULT = 1024;

  // Store operation encodings carried on store_op.
  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_W    = 2'b01,
    ST_H    = 2'b10,
    ST_B    = 2'b11
  } store_op_e;

  // Clear FSM states (kept as plain constants for legacy tool flows).
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  // A word store needs addr[1:0]==0, a halfword store needs addr[0]==0,
  // a byte store is always aligned and "no store" can never be misaligned.
  function automatic logic store_misaligned(input logic [1:0] op,
                                            input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      ST_W:    bad = (lo != 2'b00);
      ST_H:    bad = lo[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: combinational byte-lane merge for sw/sh/sb.
// Overlays the store data onto the old word; unselected lanes keep the old
// value. The word itself is chosen by the caller.
`timescale 1ns/1ps
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_op,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  // Replace only the lanes selected by the store width and low address bits.
  always_comb begin
    // NOTE: merged takes the old word first so every path assigns it and no latch is inferred.
    merged = old_word;
    case (store_op)
      ST_W: merged = wdata;
      ST_H: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      ST_B:    merged[{lane, 3'b000} +: 8] = wdata[7:0];
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// data_mem: word-organised data memory for the MEM pipeline stage.
// Combinational aligned-word read, byte-lane merged sw/sh/sb writes, and a
// post-reset clear sweep that holds busy high for DEPTH_WORDS cycles.
// Optional build macro: DM_WRITE_LOG_EN prints one line per committed store.
`timescale 1ns/1ps
module data_mem
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_op,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        align_err,
  output logic        range_err
);

  localparam int            AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] index;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          we;

  assign index    = addr[AW+1:2];
  assign old_word = mem[index];
  assign busy     = (state == S_CLEAR);

  // Any address bit above the word index means the access is off the array.
  assign range_err = ((addr >> (AW + 2)) != 32'd0);
  assign align_err = store_misaligned(store_op, addr[1:0]);

  assign we = (store_op != ST_NONE) && !busy && !align_err && !range_err;

  // Reads are suppressed during the sweep and for out-of-range addresses.
  assign rdata = (!busy && !range_err) ? old_word : 32'd0;

  dm_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (wdata),
    .store_op (store_op),
    .lane     (addr[1:0]),
    .merged   (merged)
  );

  // Clear FSM: sweep every word once after reset, then park in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + AW'(1);
      if (clr_cnt == LAST_IDX) state <= S_IDLE;
    end
  end

  // Single write port: the sweep owns it while busy, stores own it afterwards.
  // NOTE: the array is deliberately left out of reset; the sweep zeroes it so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (busy)    mem[clr_cnt] <= 32'd0;
    else if (we) mem[index]   <= merged;
  end

`ifdef DM_WRITE_LOG_EN
  // Trace each committed store with the word that actually lands in the array.
  always @(posedge clk) begin
    if (we) $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: self-checking bench for data_mem (default depth 1024).
// Read expectations come from a bench-side word model and are queued when the
// address is driven; a negedge monitor pops and compares them against rdata.
`timescale 1ns/1ps
module tb_data_mem;
  import dm_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  store_op;
  logic [31:0] rdata;
  logic        busy;
  logic        align_err;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    exp_q[$];
  sb_item_t    mon_item;
  logic [31:0] model_mem [DEPTH];

  data_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .addr      (addr),
    .wdata     (wdata),
    .store_op  (store_op),
    .rdata     (rdata),
    .busy      (busy),
    .align_err (align_err),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: one expected read word per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      checks++;
      if (rdata !== mon_item.exp) begin
        errors++;
        $display("FAIL %s: rdata=%h expected %h", mon_item.name, rdata, mon_item.exp);
      end
    end
  end

  function automatic bit ref_range(input logic [31:0] a);
    return (a >> 2) >= DEPTH;
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] op, input logic [31:0] a);
    if (op == 2'b01) return a[1:0] != 2'b00;
    if (op == 2'b10) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_range(a)) return 32'd0;
    return model_mem[ref_idx(a)];
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] op, input logic [1:0] lo);
    logic [31:0] r;
    r = old;
    if (op == 2'b01) r = d;
    else if (op == 2'b10) begin
      if (lo[1]) r = {d[15:0], old[15:0]};
      else       r = {old[31:16], d[15:0]};
    end else if (op == 2'b11) begin
      case (lo)
        2'd0: r = {old[31:8], d[7:0]};
        2'd1: r = {old[31:16], d[7:0], old[7:0]};
        2'd2: r = {old[31:24], d[7:0], old[15:0]};
        default: r = {d[7:0], old[23:0]};
      endcase
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endtask

  // Drive one store (memory idle); queue the old word seen during the store cycle.
  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    sb_item_t it;
    @(posedge clk); #1;
    addr = a; wdata = d; store_op = op;
    it.name = $sformatf("store_cycle_read@%h", a);
    it.exp  = ref_read(a);
    exp_q.push_back(it);
    if (op != 2'b00 && !ref_misaligned(op, a) && !ref_range(a))
      model_mem[ref_idx(a)] = ref_merge(model_mem[ref_idx(a)], d, op, a[1:0]);
  endtask

  task automatic do_read_exp(input logic [31:0] a, input logic [31:0] e, input string nm);
    sb_item_t it;
    @(posedge clk); #1;
    addr = a; store_op = ST_NONE; wdata = 32'd0;
    it.name = nm; it.exp = e;
    exp_q.push_back(it);
  endtask

  // Count cycles from now until busy drops; returns the count (bounded).
  task automatic count_busy(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 4 * DEPTH);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0; pc = 32'h0; wdata = 32'd0; addr = 32'h6; store_op = ST_W;
    repeat (3) @(posedge clk); #1;
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (rdata !== 32'd0)    begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL reset_align: got %b want 1", align_err); end
    addr = 32'h1000; #1;
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL reset_range: got %b want 1", range_err); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_ok: got %b want 0", align_err); end
    addr = 32'h0; store_op = ST_NONE;
    @(posedge clk); #1;
    reset = 1'b1;
    count_busy(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL sweep_len: busy cycles %0d want %0d", n, DEPTH); end
    model_clear();
    do_read_exp(32'h0,   32'h0, "sweep_word0");
    do_read_exp(32'hFFC, 32'h0, "sweep_wordlast");
  endtask

  task automatic test_merge();
    do_store(ST_W, 32'h10, 32'h12345678);
    do_store(ST_H, 32'h12, 32'h0000BEEF);
    do_store(ST_B, 32'h11, 32'h000000AA);
    do_read_exp(32'h10, 32'hBEEFAA78, "merge_word");
    do_store(ST_H, 32'h14, 32'hFFFF1357);
    do_read_exp(32'h14, 32'h00001357, "sh_low_half");
  endtask

  task automatic test_align();
    do_store(ST_W, 32'h04, 32'h11223344);
    do_store(ST_W, 32'h06, 32'h99999999); #1;
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sw06: got %b want 1", align_err); end
    do_store(ST_H, 32'h03, 32'h00007777); #1;
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sh03: got %b want 1", align_err); end
    do_store(ST_H, 32'h01, 32'h00006666); #1;
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sh01: got %b want 1", align_err); end
    do_store(ST_B, 32'h03, 32'h0000005A); #1;
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_sb03: got %b want 0", align_err); end
    do_store(ST_NONE, 32'h07, 32'h0); #1;
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_none: got %b want 0", align_err); end
    do_read_exp(32'h04, 32'h11223344, "align_word1_kept");
    do_read_exp(32'h00, 32'h5A000000, "align_sb_lane3");
  endtask

  task automatic test_range();
    do_store(ST_W, 32'h1000, 32'hDEADBEEF); #1;
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_1000: got %b want 1", range_err); end
    do_store(ST_B, 32'h80000003, 32'h00000011); #1;
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_high: got %b want 1", range_err); end
    do_store(ST_W, 32'hFFC, 32'h0BADF00D); #1;
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_last_ok: got %b want 0", range_err); end
    do_read_exp(32'h00,   32'h5A000000, "range_no_alias");
    do_read_exp(32'h1000, 32'h0,        "range_read_zero");
    do_read_exp(32'hFFC,  32'h0BADF00D, "range_last_word");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a;
    do_store(ST_W, 32'h40, 32'hA5A5A5A5);
    do_store(ST_W, 32'h40, 32'h0F0F0F0F);
    do_read_exp(32'h40, 32'h0F0F0F0F, "same_addr_new");
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(1, 3));
      a  = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      do_store(op, a, $urandom);
    end
    for (int i = 0; i < 8; i++)
      do_read_exp(32'h100 + 32'(i) * 4, model_mem[64 + i], $sformatf("b2b_word%0d", i));
    do_store(ST_W, 32'hFF0, 32'hCAFEF00D);
  endtask

  task automatic test_busy_drop();
    int n;
    sb_item_t it;
    @(posedge clk); #1;
    store_op = ST_NONE; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; addr = 32'hFF0;
    it.name = "busy_read_gated"; it.exp = 32'h0;
    exp_q.push_back(it);
    repeat (100) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      addr = 32'h20; wdata = 32'hFFFFFFFF; store_op = ST_W; #1;
      checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL drop_busy: got %b want 1", busy); end
      checks++; if (rdata !== 32'd0)    begin errors++; $display("FAIL drop_rdata: got %h want 0", rdata); end
      checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL drop_align: got %b want 0", align_err); end
    end
    @(posedge clk); #1;
    store_op = ST_NONE; addr = 32'h0;
    count_busy(n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_timeout: busy=%b after %0d cycles want 0", busy, n); end
    model_clear();
    do_read_exp(32'h20,  32'h0, "drop_word20");
    do_read_exp(32'hFF0, 32'h0, "drop_resweep_ff0");
    do_read_exp(32'h10,  32'h0, "drop_resweep_10");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    reset = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: got %b want 1", busy); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    count_busy(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL mid_sweep_len: busy cycles %0d want %0d", n, DEPTH); end
    do_store(ST_W, 32'h8, 32'h00000005);
    do_read_exp(32'h8, 32'h00000005, "post_restart_store");
  endtask

  initial begin
    test_reset();
    test_merge();
    test_align();
    test_range();
    test_back_to_back();
    test_busy_drop();
    test_reset_mid_sweep();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
